// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel dispatch path.
//   X_SIZE_DEFAULT / Y_SIZE_DEFAULT : default frame geometry
//   X_W / Y_W                       : coordinate bus widths (up to 1024 x 512)
//   sched_state_t                   : frame scheduler states
package mandel_pkg;

    localparam int X_SIZE_DEFAULT = 640;
    localparam int Y_SIZE_DEFAULT = 480;
    localparam int X_W            = 10;
    localparam int Y_W            = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return to (0,0)
//   advance    : step to the next pixel (x wraps at X_SIZE-1 with y+1,
//                and the whole frame wraps back to (0,0) after the last pixel)
//   x, y       : current pixel position
//   first      : position is (0,0)
//   last_x     : position is the last pixel of a line
//   last       : position is the last pixel of the frame
module raster_counter
    import mandel_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEFAULT,
    parameter int Y_SIZE = Y_SIZE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           first,
    output logic           last_x,
    output logic           last
);

    assign first  = (x == '0) && (y == '0);
    assign last_x = (x == X_W'(X_SIZE - 1));
    assign last   = last_x && (y == Y_W'(Y_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_x) begin
                x <= '0;
                y <= last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_dispatch_scheduler.sv
// Frame scheduler that hands pixel jobs to NUM_CORES Mandelbrot iteration
// cores round-robin in raster order and re-serialises their results into a
// raster-ordered output stream.
// Ports:
//   out_stream_aclk, periph_resetn : clock, asynchronous active-low reset
//   start                          : single-cycle frame start (ignored unless idle)
//   busy, frame_done               : frame in progress, end-of-frame pulse
//   core_req_valid/ready           : per-core job handshake
//   core_req_x/y                   : shared job coordinate bus
//   core_rsp_valid/ready/iter      : per-core result handshake, core i at slice i
//   out_valid/ready/iter/x/y/sof/eol : raster-ordered result stream
module pixel_dispatch_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int X_SIZE    = X_SIZE_DEFAULT,
    parameter int Y_SIZE    = Y_SIZE_DEFAULT,
    parameter int ITER_W    = 8
) (
    input  logic                        out_stream_aclk,
    input  logic                        periph_resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    output logic [NUM_CORES-1:0]        core_req_valid,
    input  logic [NUM_CORES-1:0]        core_req_ready,
    output logic [X_W-1:0]              core_req_x,
    output logic [Y_W-1:0]              core_req_y,
    input  logic [NUM_CORES-1:0]        core_rsp_valid,
    output logic [NUM_CORES-1:0]        core_rsp_ready,
    input  logic [NUM_CORES*ITER_W-1:0] core_rsp_iter,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ITER_W-1:0]           out_iter,
    output logic [X_W-1:0]              out_x,
    output logic [Y_W-1:0]              out_y,
    output logic                        out_sof,
    output logic                        out_eol
);

    localparam int                CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

    sched_state_t          state;
    logic [NUM_CORES-1:0]  pending;
    logic [CORE_W-1:0]     iss_core;
    logic [CORE_W-1:0]     col_core;
    logic [NUM_CORES-1:0]  iss_onehot;
    logic [NUM_CORES-1:0]  col_onehot;
    logic                  iss_pending;
    logic                  col_pending;
    logic                  out_space;
    logic                  iss_fire;
    logic                  col_fire;
    logic                  out_take;
    logic                  frame_start;
    logic                  out_last;
    logic [ITER_W-1:0]     rsp_iter_sel;

    logic [X_W-1:0]        iss_x;
    logic [Y_W-1:0]        iss_y;
    logic                  iss_first;
    logic                  iss_last_x;
    logic                  iss_last;
    logic [X_W-1:0]        col_x;
    logic [Y_W-1:0]        col_y;
    logic                  col_first;
    logic                  col_last_x;
    logic                  col_last;
    logic                  unused_iss_flags;

    assign unused_iss_flags = &{1'b0, iss_first, iss_last_x};

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_issue_cnt (
        .clk     (out_stream_aclk),
        .rst_n   (periph_resetn),
        .clear   (frame_start),
        .advance (iss_fire),
        .x       (iss_x),
        .y       (iss_y),
        .first   (iss_first),
        .last_x  (iss_last_x),
        .last    (iss_last)
    );

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_collect_cnt (
        .clk     (out_stream_aclk),
        .rst_n   (periph_resetn),
        .clear   (frame_start),
        .advance (col_fire),
        .x       (col_x),
        .y       (col_y),
        .first   (col_first),
        .last_x  (col_last_x),
        .last    (col_last)
    );

    assign frame_start = (state == ST_IDLE) && start;
    assign busy        = (state != ST_IDLE);

    assign iss_onehot  = NUM_CORES'(1) << iss_core;
    assign col_onehot  = NUM_CORES'(1) << col_core;
    assign iss_pending = |(pending & iss_onehot);
    assign col_pending = |(pending & col_onehot);

    // Issue side: pending is the registered copy, so a core whose result is
    // collected this cycle only becomes eligible for a new job next cycle.
    assign core_req_valid = ((state == ST_RUN) && !iss_pending) ? iss_onehot : '0;
    assign core_req_x     = iss_x;
    assign core_req_y     = iss_y;
    assign iss_fire       = |(core_req_valid & core_req_ready);

    // Collect side: only the core owning the next raster pixel is served;
    // results from other cores wait in their own output registers.
    assign out_space      = !out_valid || out_ready;
    assign core_rsp_ready = (col_pending && out_space) ? col_onehot : '0;
    assign col_fire       = |(core_rsp_ready & core_rsp_valid);
    assign out_take       = out_valid && out_ready;

    always_comb begin
        rsp_iter_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (col_core == CORE_W'(i)) begin
                rsp_iter_sel = core_rsp_iter[i*ITER_W +: ITER_W];
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (iss_fire && iss_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_take && out_last) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Set and clear can never target the same core in one cycle: issue needs
    // the bit low, collect needs it high.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            pending  <= '0;
            iss_core <= '0;
            col_core <= '0;
        end else begin
            pending <= (pending | (iss_fire ? iss_onehot : '0))
                       & ~(col_fire ? col_onehot : '0);
            if (frame_start) begin
                iss_core <= '0;
            end else if (iss_fire) begin
                iss_core <= (iss_core == LAST_CORE) ? '0 : iss_core + 1'b1;
            end
            if (frame_start) begin
                col_core <= '0;
            end else if (col_fire) begin
                col_core <= (col_core == LAST_CORE) ? '0 : col_core + 1'b1;
            end
        end
    end

    // Output register: a collect refills it in the same cycle it drains, so a
    // steady stream moves one pixel per clock.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            out_valid <= 1'b0;
            out_iter  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_last  <= 1'b0;
        end else if (col_fire) begin
            out_valid <= 1'b1;
            out_iter  <= rsp_iter_sel;
            out_x     <= col_x;
            out_y     <= col_y;
            out_sof   <= col_first;
            out_eol   <= col_last_x;
            out_last  <= col_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
module tb_pixel_dispatch_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;

    // DUT A: 2 cores, 4x2 frame
    logic        a_busy, a_fd;
    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [9:0]  a_req_x;
    logic [8:0]  a_req_y;
    logic [15:0] a_rsp_iter;
    logic        a_out_valid, a_out_ready, a_out_sof, a_out_eol;
    logic [7:0]  a_out_iter;
    logic [9:0]  a_out_x;
    logic [8:0]  a_out_y;

    // DUT B: 1 core, 4x2 frame
    logic        b_busy, b_fd;
    logic [0:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [9:0]  b_req_x;
    logic [8:0]  b_req_y;
    logic [7:0]  b_rsp_iter;
    logic        b_out_valid, b_out_ready, b_out_sof, b_out_eol;
    logic [7:0]  b_out_iter;
    logic [9:0]  b_out_x;
    logic [8:0]  b_out_y;

    pixel_dispatch_scheduler #(
        .NUM_CORES(2), .X_SIZE(4), .Y_SIZE(2), .ITER_W(8)
    ) dut_a (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .start           (start_a),
        .busy            (a_busy),
        .frame_done      (a_fd),
        .core_req_valid  (a_req_valid),
        .core_req_ready  (a_req_ready),
        .core_req_x      (a_req_x),
        .core_req_y      (a_req_y),
        .core_rsp_valid  (a_rsp_valid),
        .core_rsp_ready  (a_rsp_ready),
        .core_rsp_iter   (a_rsp_iter),
        .out_valid       (a_out_valid),
        .out_ready       (a_out_ready),
        .out_iter        (a_out_iter),
        .out_x           (a_out_x),
        .out_y           (a_out_y),
        .out_sof         (a_out_sof),
        .out_eol         (a_out_eol)
    );

    pixel_dispatch_scheduler #(
        .NUM_CORES(1), .X_SIZE(4), .Y_SIZE(2), .ITER_W(8)
    ) dut_b (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .start           (start_b),
        .busy            (b_busy),
        .frame_done      (b_fd),
        .core_req_valid  (b_req_valid),
        .core_req_ready  (b_req_ready),
        .core_req_x      (b_req_x),
        .core_req_y      (b_req_y),
        .core_rsp_valid  (b_rsp_valid),
        .core_rsp_ready  (b_rsp_ready),
        .core_rsp_iter   (b_rsp_iter),
        .out_valid       (b_out_valid),
        .out_ready       (b_out_ready),
        .out_iter        (b_out_iter),
        .out_x           (b_out_x),
        .out_y           (b_out_y),
        .out_sof         (b_out_sof),
        .out_eol         (b_out_eol)
    );

    // Behavioural cores: index 0,1 serve DUT A, index 2 serves DUT B.
    // Result appears lat[i] cycles after the job handshake and is held until taken.
    function automatic logic [7:0] iter_of(input int x, input int y);
        return 8'(x * 16 + y * 5 + 1);
    endfunction

    int         lat [3];
    int         cnt [3];
    logic [7:0] m_iter [3];
    logic [2:0] m_req_valid, m_rsp_ready, m_rsp_valid;

    assign m_req_valid = {b_req_valid, a_req_valid};
    assign m_rsp_ready = {b_rsp_ready, a_rsp_ready};
    assign a_rsp_valid = m_rsp_valid[1:0];
    assign b_rsp_valid = m_rsp_valid[2:2];
    assign a_rsp_iter  = {m_iter[1], m_iter[0]};
    assign b_rsp_iter  = m_iter[2];
    assign a_req_ready = 2'b11;
    assign b_req_ready = 1'b1;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_rsp_valid[i] <= 1'b0;
                cnt[i]         <= 0;
            end else begin
                if (m_rsp_valid[i] && m_rsp_ready[i]) m_rsp_valid[i] <= 1'b0;
                if (m_req_valid[i]) begin
                    cnt[i] <= lat[i];
                    if (i < 2) m_iter[i] <= iter_of(int'(a_req_x), int'(a_req_y));
                    else       m_iter[i] <= iter_of(int'(b_req_x), int'(b_req_y));
                end else if (cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) m_rsp_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Observation mux for the DUT under test
    int          sel = 0;
    logic        s_out_valid, s_out_ready, s_sof, s_eol, s_fd, s_busy, s_rsp_any;
    logic [7:0]  s_iter;
    logic [9:0]  s_x, s_req_x;
    logic [8:0]  s_y, s_req_y;
    logic [1:0]  s_req_vec;

    assign s_out_valid = (sel != 0) ? b_out_valid : a_out_valid;
    assign s_out_ready = (sel != 0) ? b_out_ready : a_out_ready;
    assign s_sof       = (sel != 0) ? b_out_sof   : a_out_sof;
    assign s_eol       = (sel != 0) ? b_out_eol   : a_out_eol;
    assign s_fd        = (sel != 0) ? b_fd        : a_fd;
    assign s_busy      = (sel != 0) ? b_busy      : a_busy;
    assign s_rsp_any   = (sel != 0) ? b_rsp_ready[0] : |a_rsp_ready;
    assign s_iter      = (sel != 0) ? b_out_iter  : a_out_iter;
    assign s_x         = (sel != 0) ? b_out_x     : a_out_x;
    assign s_y         = (sel != 0) ? b_out_y     : a_out_y;
    assign s_req_x     = (sel != 0) ? b_req_x     : a_req_x;
    assign s_req_y     = (sel != 0) ? b_req_y     : a_req_y;
    assign s_req_vec   = (sel != 0) ? {1'b0, b_req_valid} : a_req_valid;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_ready(input int which, input logic v);
        if (which == 0) a_out_ready = v; else b_out_ready = v;
    endtask

    // Pulse start and check the first job request on the following cycle.
    task automatic do_start(input int which, input string name);
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        #1;
        chk({name, "_first_req_valid"}, 32'(s_req_vec), 32'd1);
        chk({name, "_first_req_xy"}, {12'd0, s_req_x, s_req_y}, 32'd0);
        chk({name, "_busy"}, 32'(s_busy), 32'd1);
    endtask

    // Follow one frame: every output handshake is checked against raster order.
    task automatic run_frame(input int which, input int start_cyc, input int stall_cyc,
                             input bit expect_hold, input string name);
        int          k = 0;
        int          cyc = 0;
        int          last_cyc = -100;
        int          fd_cnt = 0;
        int          fd_cyc = -1;
        int          held = 0;
        bit          snap_ok = 0;
        logic [31:0] snap = '0;
        logic [31:0] now;
        sel = which;
        while (cyc < 400 && !(k >= 8 && cyc >= last_cyc + 4)) begin
            @(negedge clk);
            cyc++;
            set_start(which, (cyc == start_cyc) ? 1'b1 : 1'b0);
            if (stall_cyc > 0 && cyc == stall_cyc)      set_ready(which, 1'b0);
            if (stall_cyc > 0 && cyc == stall_cyc + 10) set_ready(which, 1'b1);
            #1;
            now = {3'd0, s_iter, s_x, s_y, s_sof, s_eol};
            if (stall_cyc > 0 && cyc >= stall_cyc && cyc < stall_cyc + 10 && s_out_valid) begin
                chk({name, "_stall_rsp_ready"}, 32'(s_rsp_any), 32'd0);
                if (snap_ok) chk({name, "_stall_hold"}, now, snap);
                snap    = now;
                snap_ok = 1;
            end
            if (expect_hold && a_rsp_valid[1] && !a_rsp_ready[1]) held++;
            if (s_fd) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (s_out_valid && s_out_ready) begin
                if (k < 8) begin
                    chk($sformatf("%s_x%0d", name, k),    32'(s_x),    32'(k % 4));
                    chk($sformatf("%s_y%0d", name, k),    32'(s_y),    32'(k / 4));
                    chk($sformatf("%s_iter%0d", name, k), 32'(s_iter), 32'(iter_of(k % 4, k / 4)));
                    chk($sformatf("%s_sof%0d", name, k),  32'(s_sof),  32'(k == 0));
                    chk($sformatf("%s_eol%0d", name, k),  32'(s_eol),  32'((k % 4) == 3));
                end
                k++;
                last_cyc = cyc;
            end
        end
        chk({name, "_pixel_count"}, 32'(k), 32'd8);
        chk({name, "_frame_done_count"}, 32'(fd_cnt), 32'd1);
        chk({name, "_frame_done_timing"}, 32'(fd_cyc), 32'(last_cyc + 1));
        chk({name, "_busy_after"}, 32'(s_busy), 32'd0);
        if (expect_hold) chk({name, "_core1_held"}, 32'(held > 0), 32'd1);
    endtask

    initial begin
        int k;
        int cyc;
        rst_n       = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        lat[0] = 3; lat[1] = 3; lat[2] = 2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_busy", 32'({a_busy, b_busy}), 32'd0);
        chk("reset_req_valid", 32'({a_req_valid, b_req_valid}), 32'd0);
        chk("reset_rsp_ready", 32'({a_rsp_ready, b_rsp_ready}), 32'd0);
        chk("reset_frame_done", 32'({a_fd, b_fd}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Equal latencies, free-running output
        do_start(0, "basic");
        run_frame(0, 0, 0, 0, "basic");

        // Skewed latencies: core1 result must wait for core0
        lat[0] = 6; lat[1] = 1;
        do_start(0, "skew");
        run_frame(0, 0, 0, 1, "skew");

        // Output back-pressure for 10 cycles mid-frame
        lat[0] = 3; lat[1] = 3;
        do_start(0, "stall");
        run_frame(0, 0, 8, 0, "stall");

        // Start pulsed while running is ignored; a later start begins a fresh frame
        do_start(0, "startrun");
        run_frame(0, 3, 0, 0, "startrun");
        do_start(0, "restart");
        run_frame(0, 0, 0, 0, "restart");

        // Reset mid-frame after three outputs
        do_start(0, "rst");
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            #1;
            if (a_out_valid && a_out_ready) k++;
        end
        chk("rst_outputs_seen", 32'(k), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_frame_done", 32'(a_fd), 32'd0);
        chk("rst_req_valid", 32'(a_req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(a_rsp_ready), 32'd0);
        chk("rst_sof_eol", 32'({a_out_sof, a_out_eol}), 32'd0);
        chk("rst_data", {5'd0, a_out_iter, a_out_x, a_out_y}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start(0, "postrst");
        run_frame(0, 0, 0, 0, "postrst");

        // Single core serialises the whole frame
        do_start(1, "single");
        run_frame(1, 0, 0, 0, "single");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_dispatch_scheduler.md
PIXEL_DISPATCH_SCHEDULER -- requirements
Module: pixel_dispatch_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of Mandelbrot iteration cores served.
REQ-002 SHALL have parameter X_SIZE, default 640, pixels per line.
REQ-003 SHALL have parameter Y_SIZE, default 480, lines per frame.
REQ-004 SHALL have parameter ITER_W, default 8, iteration-count result width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: out_stream_aclk in 1, rising-edge clock; periph_resetn in 1, async active-low reset.
REQ-006 start in 1: single-cycle frame start request.
REQ-007 busy out 1: frame in progress; frame_done out 1: one-cycle end-of-frame pulse.
REQ-008 core_req_valid out NUM_CORES, core_req_ready in NUM_CORES: per-core job handshake.
REQ-009 core_req_x out 10, core_req_y out 9: shared job coordinate bus.
REQ-010 core_rsp_valid in NUM_CORES, core_rsp_ready out NUM_CORES, core_rsp_iter in NUM_CORES*ITER_W: per-core result handshake and data (core i at slice i).
REQ-011 out_valid out 1, out_ready in 1, out_iter out ITER_W, out_x out 10, out_y out 9, out_sof out 1, out_eol out 1: raster-ordered result stream.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN when X_SIZE*Y_SIZE jobs issued; DRAIN->IDLE on final pixel's out handshake; start outside IDLE ignored.
REQ-013 SHALL issue jobs in raster order (x 0..X_SIZE-1, then y+1) strictly round-robin: pixel k goes to core k mod NUM_CORES.
REQ-014 SHALL keep per-core pending bit: set on req handshake, cleared on rsp handshake; at most one outstanding job per core.
REQ-015 SHALL assert only core_req_valid[iss_core], only in RUN and only when pending[iss_core]=0; x/y stable while valid and not ready.
REQ-016 First core_req_valid SHALL assert the cycle after start is sampled.
REQ-017 SHALL collect in raster order: core_rsp_ready asserted only for col_core, only when pending[col_core]=1 and output register empty or out_ready=1; other cores' responses held.
REQ-018 On collect, output register SHALL load next cycle: out_iter=rsp slice, out_x/out_y=collect coordinates, out_sof=(x==0 && y==0), out_eol=(x==X_SIZE-1); one-cycle rsp-to-out latency.
REQ-019 Output SHALL hold all fields stable while out_valid=1 and out_ready=0; collect and output-drain in same cycle SHALL sustain one pixel per cycle.
REQ-020 Pending clear and re-issue to the same core SHALL NOT occur in the same cycle (issue sees pending one cycle later).
REQ-021 frame_done SHALL pulse the cycle after the final out handshake; busy=1 in RUN and DRAIN.
REQ-022 Issue and collect counters SHALL wrap x at X_SIZE-1 to 0 with y increment; core pointers wrap at NUM_CORES-1 to 0.

Reset
REQ-023 periph_resetn low SHALL asynchronously force IDLE, pending=0, all pointers/coordinates=0, and all outputs (valid/ready/busy/frame_done/sof/eol/data) =0, including mid-frame.
REQ-024 After reset release, the next start SHALL begin at pixel (0,0) on core 0; cores' in-flight results are the cores' own reset responsibility.

Structure
REQ-025 Shared package mandel_pkg SHALL hold X_SIZE/Y_SIZE defaults, coordinate widths (10/9), and the state enum.
REQ-026 Sub-module raster_counter (x/y counter with wrap, first/last flags) SHALL be instantiated twice: issue and collect.

Verification (bench params X_SIZE=4, Y_SIZE=2, NUM_CORES=2)
REQ-027 Cores fixed 3-cycle latency, out_ready=1, start -> 8 pixels out (0,0)..(3,1) in order, sof only on (0,0), eol on x=3, one frame_done.
REQ-028 Core1 latency 1, core0 latency 6 -> output order unchanged; core1 rsp held until core0 collected.
REQ-029 out_ready=0 for 10 cycles mid-frame -> out fields stable, core_rsp_ready all 0, no pixel lost or duplicated.
REQ-030 start pulsed during RUN -> ignored; start after frame_done -> new frame beginning with sof at (0,0).
REQ-031 periph_resetn low after 3 outputs -> all outputs 0 immediately, busy=0; next start restarts at (0,0) on core 0.
REQ-032 NUM_CORES=1 -> 8 pixels serialised on core 0, correct sof/eol, frame_done once.
